fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end. It reads the current PC from program_counter and drives that block's next-PC value and load enable.
- Fetches instruction words from instruction memory over a req/ack handshake and buffers them in a small queue.
- Hands instructions to decode with a valid/ready handshake.
- Accepts redirects (branch/jump) from execute.

Parameters:
QDEPTH, 2, instruction queue depth in entries (power of two, >=2)
RESET_PC, 32'h3000, documentation and bench constant; must match the program_counter reset value

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
c_pc  input  32  current PC from program_counter
n_pc  output  32  next PC to program_counter
pc_en  output  1  load enable to program_counter; the PC loads n_pc on the clock edge while pc_en=1
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of the request; equals c_pc while the request is held
imem_ack  input  1  memory completed the access this cycle
imem_rdata  input  32  instruction word, valid only when imem_ack=1
id_valid  output  1  queue head holds a valid instruction
id_ready  input  1  decode accepts the head this cycle
id_inst  output  32  head instruction
id_pc  output  32  PC of head instruction
redirect  input  1  execute requests a fetch redirect (one-cycle pulse)
redirect_pc  input  32  redirect target, word aligned

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk.
- Reset state: FSM=IDLE, queue empty. Outputs: id_valid=0, imem_req=0, pc_en=0, n_pc=c_pc+4.
- The bench drives program_counter's rstn from ~rst.
- FSM states:
  - IDLE: imem_req=0. Moves to REQ on the next edge when count<QDEPTH and redirect=0.
  - REQ: imem_req=1, imem_addr=c_pc. The request is held stable until imem_ack.
    - On ack with redirect=0: push {c_pc, imem_rdata}; pc_en=1, n_pc=c_pc+4. Go to REQ if count after this cycle's push and pop is <QDEPTH, else IDLE.
    - Redirect without ack: go to DRAIN.
  - DRAIN: imem_req=1 with imem_addr held at the abandoned address, which is latched in a register because c_pc has already changed. On ack the data is discarded and the FSM goes to IDLE.
- Redirect, any state, one cycle:
  - pc_en=1, n_pc=redirect_pc.
  - Queue flushed, so id_valid=0 on the next cycle.
  - Any push in the same cycle is suppressed.
  - Redirect takes priority over the sequential n_pc.
  - Redirect in the same cycle as ack: the data is discarded and the FSM goes to IDLE, not DRAIN.
  - Redirect while in DRAIN: the new target is loaded; the FSM stays in DRAIN.
- Default when not loading: pc_en=0, n_pc=c_pc+4 with 32-bit wrap; 0xFFFFFFFC+4 = 0x00000000.
- Queue:
  - Circular buffer with rd/wr pointers of log2(QDEPTH) bits and a count of log2(QDEPTH)+1 bits.
  - Pop when id_valid & id_ready.
  - Push and pop in the same cycle are allowed at any count; count is unchanged.
  - id_inst/id_pc come directly from the head entry. They are combinational from registers and stable while id_valid=1 & id_ready=0.
- Throughput: one instruction per cycle when imem_ack is tied high and id_ready=1.
- Latency: a word acked at edge N is visible on id_valid after edge N, i.e. in cycle N+1.
- Only one memory access is ever outstanding. A request is never issued when the queue is full.
- Reset asserted mid-access: the FSM returns to IDLE. The memory model must also be reset; no drain is performed.

Decomposition:
- Shared package fetch_pkg:
  - RESET_PC
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DRAIN=2'd2)
  - fetch_entry record {pc[31:0], inst[31:0]}
- Sub-module inst_queue: parameterised QDEPTH FIFO with push, pop, flush, count, full, empty and head outputs.
- fetch_unit holds the FSM, the n_pc/pc_en mux and the DRAIN address register.

Test Plan:
- Reset, then release with imem_ack=1 and id_ready=1 → imem_addr=0x3000 in the first REQ cycle. id_pc sequence is 0x3000, 0x3004, 0x3008 on consecutive cycles with matching id_inst.
- id_ready=0 for 6 cycles, ack always high → exactly 2 entries queued. imem_req drops after the second ack. c_pc holds at 0x3008. id_inst is stable throughout.
- Redirect to 0x4000 while the queue holds 0x3000/0x3004 and no access is pending → id_valid=0 next cycle. The next request is 0x4000 and the first id_pc is 0x4000.
- Redirect to 0x5000 while a REQ to 0x3008 is held and the ack arrives 3 cycles later → imem_addr stays 0x3008 until the ack. The word is discarded. The next request is 0x5000.
- Redirect coinciding with the ack of 0x300C → no push of 0x300C. c_pc becomes the redirect target and there is no DRAIN cycle.
- rst asserted during REQ with the ack pending, memory model also reset → next cycle imem_req=0 and id_valid=0. After rst deasserts (PC reset back to 0x3000), the first request is 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundles the PC, instruction-memory, decode and redirect signals of the fetch unit.
interface fetch_if;
  logic [31:0] c_pc;
  logic [31:0] n_pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    input  c_pc, imem_ack, imem_rdata, id_ready, redirect, redirect_pc,
    output n_pc, pc_en, imem_req, imem_addr, id_valid, id_inst, id_pc
  );

  modport slave (
    output c_pc, imem_ack, imem_rdata, id_ready, redirect, redirect_pc,
    input  n_pc, pc_en, imem_req, imem_addr, id_valid, id_inst, id_pc
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Small circular instruction buffer between memory and decode; flush empties it in one cycle.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  input  logic                      flush,
  output fetch_entry_t              head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage needs no reset; only the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: request FSM, next-PC mux, abandoned-address register and instruction queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state;
  logic          req_q;
  logic [31:0]   drain_addr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign push       = !rst && (state == REQ) && bus.imem_ack && !bus.redirect;
  assign pop        = !empty && bus.id_ready;
  assign push_data  = '{pc: bus.c_pc, inst: bus.imem_rdata};
  assign count_next = count + CW'(push) - CW'(pop);

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = (state == DRAIN) ? drain_addr : bus.c_pc;
  assign bus.id_valid  = !empty;
  assign bus.id_inst   = head.inst;
  assign bus.id_pc     = head.pc;

  inst_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Next-PC mux: a redirect outranks the sequential step taken on an accepted fetch.
  always_comb begin
    bus.pc_en = 1'b0;
    bus.n_pc  = bus.c_pc + 32'd4;
    if (!rst && bus.redirect) begin
      bus.pc_en = 1'b1;
      bus.n_pc  = bus.redirect_pc;
    end else if (push) begin
      bus.pc_en = 1'b1;
    end
  end

  // Request FSM; a redirect without ack leaves the old access to finish in DRAIN at its latched address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      drain_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (!full && !bus.redirect) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (bus.redirect || (count_next >= CW'(QDEPTH))) begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end else if (bus.redirect) begin
            state      <= DRAIN;
            drain_addr <= bus.c_pc;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
